// File: rtl/imem_load_if.sv
// imem_load_if: byte-receiver input and instruction-memory write-port bundle for imem_load_controller
interface imem_load_if #(parameter int ADDR_W = 6) ();
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  modport master (input rx_data, rx_valid, output rx_ready, mem_we, mem_waddr, mem_wdata);
  modport slave (output rx_data, rx_valid, input rx_ready, mem_we, mem_waddr, mem_wdata);
endinterface

// File: rtl/imem_load_controller.sv
// imem_load_controller: packs a marker-framed byte stream MSB-first into words and writes them to instruction memory
// Optional IMEM_CSUM_EN adds a trailing checksum byte check and the csum_err output.
module imem_load_controller #(
  parameter int         ADDR_W     = 6,
  parameter logic [7:0] START_BYTE = 8'hFE,
  parameter logic [7:0] END_BYTE   = 8'hFF
) (
  input  logic              clk,
  input  logic              reset,
  imem_load_if.master       bus,
  output logic              cpu_hold,
  output logic              load_done,
  output logic [ADDR_W:0]   word_count,
  output logic              overflow_err
`ifdef IMEM_CSUM_EN
  ,
  output logic              csum_err
`endif
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FLUSH, S_CSUM, S_DONE} state_t;
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  state_t            r_state, w_next;
  logic [1:0]        r_lane;
  logic [31:0]       r_word;
  logic [ADDR_W:0]   r_count;
  logic              r_ovf, r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [31:0]       r_wdata;
  logic [7:0]        r_sum;
  logic              r_csum_err;
  logic              w_acc, w_start, w_end, w_data, w_open;
  assign bus.rx_ready = !reset && r_state != S_FLUSH;
  assign w_acc        = bus.rx_valid && bus.rx_ready;
  assign w_start      = bus.rx_data == START_BYTE;
  assign w_end        = bus.rx_data == END_BYTE;
  assign w_open       = w_acc && w_start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_data       = w_acc && !w_end && r_state == S_LOAD;
  assign bus.mem_we    = r_we;
  assign bus.mem_waddr = r_waddr;
  assign bus.mem_wdata = r_wdata;
  assign cpu_hold      = r_state != S_DONE;
  assign load_done     = r_state == S_DONE;
  assign word_count    = r_count;
  assign overflow_err  = r_ovf;
`ifdef IMEM_CSUM_EN
  assign csum_err      = r_csum_err;
`endif
  always_ff @(posedge clk)
    r_state <= reset ? S_IDLE : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: w_next = w_open ? S_LOAD : r_state;
      S_LOAD:         w_next = (w_acc && w_end) ? S_FLUSH : S_LOAD;
`ifdef IMEM_CSUM_EN
      S_FLUSH:        w_next = S_CSUM;
      S_CSUM:         w_next = w_acc ? S_DONE : S_CSUM;
`else
      S_FLUSH:        w_next = S_DONE;
`endif
      default:        w_next = S_IDLE;
    endcase
  end
  // A new word always starts from zero so a flushed partial word has zeroed low lanes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lane     <= '0;
      r_word     <= '0;
      r_count    <= '0;
      r_ovf      <= 1'b0;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_sum      <= '0;
      r_csum_err <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (w_open) begin
        r_lane     <= '0;
        r_word     <= '0;
        r_count    <= '0;
        r_ovf      <= 1'b0;
        r_sum      <= '0;
        r_csum_err <= 1'b0;
      end
      if (w_data) begin
        r_sum <= r_sum + bus.rx_data;
        if (r_count == DEPTH)
          r_ovf <= 1'b1;
        else if (r_lane == 2'd3) begin
          r_we    <= 1'b1;
          r_waddr <= r_count[ADDR_W-1:0];
          r_wdata <= {r_word[31:8], bus.rx_data};
          r_count <= r_count + 1'b1;
          r_lane  <= '0;
        end else begin
          if (r_lane == 2'd0)
            r_word <= {bus.rx_data, 24'h0};
          else
            r_word[{~r_lane, 3'b000} +: 8] <= bus.rx_data;
          r_lane <= r_lane + 1'b1;
        end
      end
      if (r_state == S_LOAD && w_acc && w_end && r_lane != 2'd0 && !r_ovf) begin
        r_we    <= 1'b1;
        r_waddr <= r_count[ADDR_W-1:0];
        r_wdata <= r_word;
        r_count <= r_count + 1'b1;
        r_lane  <= '0;
      end
      if (r_state == S_CSUM && w_acc)
        r_csum_err <= bus.rx_data != r_sum;
    end
  end
endmodule

// File: tb/tb_imem_load_controller.sv
// tb_imem_load_controller: directed byte streams into a 64-word and a 4-word controller sharing one input stream
module tb_imem_load_controller;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  imem_load_if #(.ADDR_W(6)) b_if ();
  imem_load_if #(.ADDR_W(2)) s_if ();
  assign s_if.rx_data  = b_if.rx_data;
  assign s_if.rx_valid = b_if.rx_valid;
  logic       b_hold, b_done, b_ovf, s_hold, s_done, s_ovf;
  logic [6:0] b_cnt;
  logic [2:0] s_cnt;
`ifdef IMEM_CSUM_EN
  logic       b_cerr, s_cerr;
`endif
  imem_load_controller #(.ADDR_W(6)) u_dut (
    .clk(clk), .reset(reset), .bus(b_if.master), .cpu_hold(b_hold), .load_done(b_done),
    .word_count(b_cnt), .overflow_err(b_ovf)
`ifdef IMEM_CSUM_EN
    , .csum_err(b_cerr)
`endif
  );
  imem_load_controller #(.ADDR_W(2)) u_small (
    .clk(clk), .reset(reset), .bus(s_if.master), .cpu_hold(s_hold), .load_done(s_done),
    .word_count(s_cnt), .overflow_err(s_ovf)
`ifdef IMEM_CSUM_EN
    , .csum_err(s_cerr)
`endif
  );
  int n_tests = 0;
  int n_fail = 0;
  int b_wr = 0;
  int s_wr = 0;
  logic [5:0]  b_addr;
  logic [31:0] b_data;
  logic [1:0]  s_addr;
  logic [31:0] s_data;
  always @(negedge clk) begin
    if (b_if.mem_we) begin
      b_wr++;
      b_addr = b_if.mem_waddr;
      b_data = b_if.mem_wdata;
    end
    if (s_if.mem_we) begin
      s_wr++;
      s_addr = s_if.mem_waddr;
      s_data = s_if.mem_wdata;
    end
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    int n = 0;
    b_if.rx_data  = b;
    b_if.rx_valid = 1'b1;
    @(negedge clk);
    while (!b_if.rx_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("ready_timeout", 0, 1);
    @(posedge clk);
    #1 b_if.rx_valid = 1'b0;
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic pulse_reset();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
  endtask
  task automatic csum(input logic [7:0] s);
`ifdef IMEM_CSUM_EN
    send(s);
`else
    if (s === 8'hxx) step(0);
`endif
  endtask
  initial begin
    b_if.rx_data  = 8'h00;
    b_if.rx_valid = 1'b0;
    step(3);
    check("rst_ready", b_if.rx_ready, 0);
    check("rst_we", b_if.mem_we, 0);
    check("rst_waddr", b_if.mem_waddr, 0);
    check("rst_wdata", b_if.mem_wdata, 0);
    check("rst_hold", b_hold, 1);
    check("rst_done", b_done, 0);
    check("rst_cnt", b_cnt, 0);
    check("rst_ovf", b_ovf, 0);
    reset = 1'b0;
    #1 check("idle_ready", b_if.rx_ready, 1);
    // full word
    send(8'hFE); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    check("t1_we", b_if.mem_we, 1);
    check("t1_addr", b_if.mem_waddr, 0);
    check("t1_data", b_if.mem_wdata, 32'h11223344);
    send(8'hFF);
    check("t1_done_early", b_done, 0);
    check("t1_flush_ready", b_if.rx_ready, 0);
    csum(8'hAA);
    step(1);
    check("t1_done", b_done, 1);
    check("t1_hold", b_hold, 0);
    check("t1_cnt", b_cnt, 1);
    check("t1_writes", b_wr, 1);
    // partial word flushed at end
    b_wr = 0;
    send(8'hFE);
    check("t2_hold_reload", b_hold, 1);
    send(8'hAA); send(8'hBB); send(8'hFF);
    check("t2_we", b_if.mem_we, 1);
    check("t2_addr", b_if.mem_waddr, 0);
    check("t2_data", b_if.mem_wdata, 32'hAABB0000);
    csum(8'h65);
    step(1);
    check("t2_cnt", b_cnt, 1);
    check("t2_writes", b_wr, 1);
    check("t2_done", b_done, 1);
    // overflow on the 4-word instance
    b_wr = 0;
    s_wr = 0;
    send(8'hFE);
    for (int i = 1; i <= 20; i++) send(8'(i));
    send(8'hFF);
    csum(8'hD2);
    step(2);
    check("t3_s_writes", s_wr, 4);
    check("t3_s_addr", s_addr, 3);
    check("t3_s_data", s_data, 32'h0D0E0F10);
    check("t3_s_ovf", s_ovf, 1);
    check("t3_s_cnt", s_cnt, 4);
    check("t3_s_done", s_done, 1);
    check("t3_b_writes", b_wr, 5);
    check("t3_b_data", b_data, 32'h11121314);
    check("t3_b_ovf", b_ovf, 0);
    check("t3_b_cnt", b_cnt, 5);
    // reset mid-load
    b_wr = 0;
    send(8'hFE);
    for (int i = 1; i <= 6; i++) send(8'(i));
    pulse_reset();
    check("t4_hold", b_hold, 1);
    check("t4_done", b_done, 0);
    check("t4_cnt", b_cnt, 0);
    step(5);
    check("t4_writes", b_wr, 1);
    send(8'hFE); send(8'hA1); send(8'hA2); send(8'hA3); send(8'hA4);
    check("t4_addr", b_if.mem_waddr, 0);
    check("t4_data", b_if.mem_wdata, 32'hA1A2A3A4);
    check("t4_writes2", b_wr, 1);
    send(8'hFF);
    csum(8'h8A);
    // IDLE ignores data, START inside LOAD is data, gaps allowed
    pulse_reset();
    b_wr = 0;
    send(8'h12); send(8'h34);
    step(2);
    check("t5_idle_hold", b_hold, 1);
    check("t5_idle_cnt", b_cnt, 0);
    send(8'hFE); step(2); send(8'hFE); step(3); send(8'h01); send(8'h02); step(1); send(8'h03);
    check("t5_no_write_yet", b_wr, 0);
    step(4);
    send(8'hFF);
    check("t5_addr", b_if.mem_waddr, 0);
    check("t5_data", b_if.mem_wdata, 32'hFE010203);
    csum(8'h04);
    step(1);
    check("t5_cnt", b_cnt, 1);
    check("t5_writes", b_wr, 1);
    check("t5_done", b_done, 1);
`ifdef IMEM_CSUM_EN
    send(8'hFE); send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'hFF); send(8'h0A);
    step(1);
    check("t6_good_err", b_cerr, 0);
    check("t6_good_done", b_done, 1);
    send(8'hFE); send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'hFF);
    step(1);
    check("t6_csum_wait", b_done, 0);
    send(8'h0B);
    step(1);
    check("t6_bad_err", b_cerr, 1);
    check("t6_bad_done", b_done, 1);
    check("t6_bad_hold", b_hold, 0);
    send(8'hFE);
    check("t6_err_clear", b_cerr, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
